// File: rtl/div_pkg.sv
// Shared constants for the RV64M divide controller: op codes, FSM state
// encoding, iteration counter width and per-width iteration counts.
package div_pkg;

    localparam logic [3:0] DIV_OP_DIVW  = 4'd0;
    localparam logic [3:0] DIV_OP_REMW  = 4'd1;
    localparam logic [3:0] DIV_OP_DIVU  = 4'd2;
    localparam logic [3:0] DIV_OP_DIVUW = 4'd3;
    localparam logic [3:0] DIV_OP_REMU  = 4'd4;
    localparam logic [3:0] DIV_OP_REMUW = 4'd5;
    localparam logic [3:0] DIV_OP_DIV   = 4'd6;
    localparam logic [3:0] DIV_OP_REM   = 4'd7;

    typedef logic [2:0] div_state_t;
    localparam div_state_t ST_IDLE  = 3'd0;
    localparam div_state_t ST_PREP  = 3'd1;
    localparam div_state_t ST_CALC  = 3'd2;
    localparam div_state_t ST_FIXUP = 3'd3;
    localparam div_state_t ST_DONE  = 3'd4;

    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] ITER_W = 7'd31;
    localparam logic [CNT_W-1:0] ITER_D = 7'd63;

    function automatic logic op_is_w(input logic [3:0] op);
        return op inside {DIV_OP_DIVW, DIV_OP_REMW, DIV_OP_DIVUW, DIV_OP_REMUW};
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return op inside {DIV_OP_DIVW, DIV_OP_REMW, DIV_OP_DIV, DIV_OP_REM};
    endfunction

    function automatic logic op_is_rem(input logic [3:0] op);
        return op inside {DIV_OP_REMW, DIV_OP_REMU, DIV_OP_REMUW, DIV_OP_REM};
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // rem_in < divisor always holds, so the true difference fits in XLEN bits
    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted[XLEN-1:0] - divisor;
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative RV64M divide/remainder unit with valid/ready in and out.
// Optional DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    div_state_t       state;
    logic [3:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  dq, dv, rq;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, neg_r;

    logic             w_op, s_op, n1, n2, dz, ovf, early, q_bit;
    logic [XLEN-1:0]  a1, a2, m1, m2, min_pat, r_nx, q_fix, r_fix, sel, res;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // dq/dv hold the raw operands during PREP; afterwards dq is the shifting
    // dividend that fills with quotient bits and dv is the divisor magnitude.
    always_comb begin
        w_op    = op_is_w(op_q);
        s_op    = op_is_signed(op_q);
        a1      = w_op ? {{(XLEN-32){s_op & dq[31]}}, dq[31:0]} : dq;
        a2      = w_op ? {{(XLEN-32){s_op & dv[31]}}, dv[31:0]} : dv;
        n1      = s_op & a1[XLEN-1];
        n2      = s_op & a2[XLEN-1];
        m1      = n1 ? -a1 : a1;
        m2      = n2 ? -a2 : a2;
        min_pat = w_op ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        dz      = (a2 == '0);
        ovf     = s_op && (a2 == '1) && (a1 == min_pat);
`ifdef DIV_EARLY_OUT_EN
        early   = (m1 < m2);
`else
        early   = 1'b0;
`endif
        q_fix   = neg_q ? -dq : dq;
        r_fix   = neg_r ? -rq : rq;
        sel     = op_is_rem(op_q) ? r_fix : q_fix;
        res     = w_op ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rq),
        .dvd_bit (dq[XLEN-1]),
        .divisor (dv),
        .rem_out (r_nx),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            tag_q      <= '0;
            dq         <= '0;
            dv         <= '0;
            rq         <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush && state != ST_IDLE) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid && !flush) begin
                    op_q  <= in_op;
                    tag_q <= in_tag;
                    dq    <= in_src1;
                    dv    <= in_src2;
                    state <= ST_PREP;
                end
                ST_PREP: begin
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    state <= ST_FIXUP;
                    // fast-path values are stored pre-fixup; FIXUP only selects and sign-extends
                    if (op_is_illegal(op_q)) begin
                        dq <= '0;
                        rq <= '0;
                    end else if (dz) begin
                        dq <= '1;
                        rq <= dq;
                    end else if (ovf) begin
                        rq <= '0;
                    end else if (early) begin
                        dq <= '0;
                        rq <= dq;
                    end else begin
                        dq    <= w_op ? {m1[31:0], 32'b0} : m1;
                        dv    <= m2;
                        rq    <= '0;
                        neg_q <= n1 ^ n2;
                        neg_r <= n1;
                        cnt   <= w_op ? ITER_W : ITER_D;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dq <= {dq[XLEN-2:0], q_bit};
                    rq <= r_nx;
                    if (cnt == '0) state <= ST_FIXUP;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ST_FIXUP: begin
                    out_result <= res;
                    out_tag    <= tag_q;
                    out_valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequential controller and iterative datapath for the RV64M divide group: div, divu, rem, remu, divw, divuw, remw and remuw.
- Radix-2 restoring shift-subtract engine driven by an FSM and an iteration counter.
- Sits in the EXU beside the combinational ALU. The issue stage hands it one operation through a valid/ready handshake; it returns one tagged result to writeback through a second valid/ready handshake.
- Produces RISC-V-defined results for divide-by-zero and signed overflow. Raw HDL operator results are never used for those cases.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- TAG_W, 4, width of the opaque tag passed from input to output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  controller can accept an operation.
- in_op  in  4  0 divw, 1 remw, 2 divu, 3 divuw, 4 remu, 5 remuw, 6 div, 7 rem. Codes 8-15 are illegal.
- in_src1  in  64  dividend.
- in_src2  in  64  divisor.
- in_tag  in  TAG_W  opaque tag.
- flush  in  1  kill the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  64  quotient or remainder, final form.
- out_tag  out  TAG_W  tag of the returned operation.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset and clocking: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, out_valid 0, out_result 0, out_tag 0, busy 0, counter 0. in_ready equals (state==IDLE) and therefore reads 1 once reset is released.
- Accept: occurs when in_valid && in_ready && !flush. Op, operands and tag are latched, and the state goes to PREP.
- States:
  - IDLE -> PREP on accept.
  - PREP -> CALC normally; PREP -> FIXUP on the fast path.
  - CALC -> FIXUP when the counter reaches 0.
  - FIXUP -> DONE.
  - DONE -> IDLE when out_ready is high.
- PREP:
  - W ops use the low 32 bits of each source. Signed ops (0, 1, 6, 7) take the magnitude of each operand.
  - Record neg_q = s1^s2 and neg_r = sign of the dividend.
  - Load the counter with 31 for W ops or 63 otherwise.
- Fast path: taken for a zero divisor, signed overflow, or an illegal op.
  - Divide by zero: quotient is all ones at the working width; remainder is the dividend.
  - Signed overflow (div with 0x8000_0000_0000_0000 / -1, or divw with 0x8000_0000 / -1): quotient is the dividend; remainder is 0.
  - Illegal op: result is 0.
- CALC, one step per cycle:
  - Partial remainder R = {R, next dividend bit}.
  - If R >= divisor, then R -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - Counter decrements each step.
- FIXUP:
  - Negate the quotient if neg_q, and the remainder if neg_r (signed ops only).
  - Select quotient or remainder according to op.
  - W ops sign-extend bit 31 into [63:32]. This includes divuw and remuw.
- DONE: out_valid=1. out_result and out_tag stay stable until out_ready is seen.
- Latency, with the accept cycle as T:
  - out_valid first high at T+67 for 64-bit ops.
  - T+35 for W ops.
  - T+3 on the fast path.
  - Throughput is one operation per latency period plus one IDLE cycle. There is no accept while in DONE.
- flush:
  - In any non-IDLE state: the next state is IDLE and out_valid drops on the next edge; the result is discarded.
  - In IDLE: flush blocks acceptance in the same cycle.
  - flush has priority over out_ready.
- Reset asserted mid-operation: immediate return to the reset values; no result is produced.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined:
  - PREP also compares magnitudes. If |dividend| < |divisor| (divisor nonzero), the fast path is taken with quotient 0 and remainder equal to the original signed dividend, giving a latency of T+3.
  - Signs and W sign-extension are applied as normal.
- When undefined: such operations run the full iteration count. Results are identical either way; only latency differs.

Decomposition:
- Package div_pkg holds:
  - op code localparams DIV_OP_DIVW through DIV_OP_REM.
  - FSM state enum (IDLE, PREP, CALC, FIXUP, DONE).
  - counter width (7 bits).
  - iteration-count constants (31, 63).
- One natural sub-module, div_step: a purely combinational single shift-subtract step taking partial remainder, dividend bit and divisor, and returning the next remainder and the quotient bit. The top level contains the FSM, counter and sign fixup.

Test Plan:
- div, src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2 -> out_result 0xFFFF_FFFF_FFFF_FFFD (-3). out_valid at T+67. out_tag echoes in_tag=0xA.
- remw, src1=0x0000_0000_FFFF_FFF9 (-7 in the low word), src2=2 -> out_result 0xFFFF_FFFF_FFFF_FFFF (-1). out_valid at T+35.
- divu with src2=0 and src1=5 -> 0xFFFF_FFFF_FFFF_FFFF at T+3. remu with the same operands -> 5.
- div 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; rem -> 0. Both take the fast path.
- divuw, src1=0xFFFF_FFFF, src2=1, with out_ready held low for 10 cycles:
  - result 0xFFFF_FFFF_FFFF_FFFF holds stable with in_ready=0.
  - accepted on the first out_ready cycle; IDLE on the next cycle.
- Flush scenarios:
  - flush asserted at CALC iteration 20 -> IDLE on the next edge, out_valid never rises, and a new op is accepted afterwards.
  - rst_n pulsed low mid-CALC -> all outputs return to reset values asynchronously.
